// File: rtl/div_feeder.sv
`default_nettype none
// ============================================================================
// Module   : div_feeder
// Brief    : Operand FIFO and in-order result collector around the iterative
//            divider; synthesises divide-by-zero results locally.
//            Optional job/dbz statistics: define DIV_FEEDER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module div_feeder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_x,
  input  logic [WIDTH-1:0] s_y,
  output logic             div_in_valid,
  input  logic             div_in_ready,
  output logic [WIDTH-1:0] div_x,
  output logic [WIDTH-1:0] div_y,
  input  logic             div_out_valid,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  input  logic             div_dbz,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_q,
  output logic [WIDTH-1:0] m_r,
  output logic             m_dbz
`ifdef DIV_FEEDER_STATS_EN
  ,
  output logic [15:0]      stat_jobs,
  output logic [15:0]      stat_dbz
`endif
);

  localparam int            c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_AW:0] c_FULL_CNT = DEPTH[c_AW:0];

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Operand FIFO
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_mem_x [DEPTH];
  logic [WIDTH-1:0] r_mem_y [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_issue;
  logic             w_drain;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL_CNT);
  assign s_ready = !w_full;
  assign w_push  = s_valid && s_ready;
  assign w_drain = m_valid && m_ready;

  assign div_x = w_empty ? '0 : r_mem_x[r_rd_ptr];
  assign div_y = w_empty ? '0 : r_mem_y[r_rd_ptr];

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_x[r_wr_ptr] <= s_x;
      r_mem_y[r_wr_ptr] <= s_y;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Issue / capture FSM
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic [WIDTH-1:0] w_load_q;
  logic [WIDTH-1:0] w_load_r;
  logic             w_load_dbz;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    div_in_valid = 1'b0;
    w_issue      = 1'b0;
    w_load       = 1'b0;
    w_load_q     = '0;
    w_load_r     = '0;
    w_load_dbz   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Holding off while a result waits keeps drain and issue disjoint.
        div_in_valid = !w_empty && !m_valid;
        w_issue      = div_in_valid && div_in_ready;
        if (w_issue) begin
          if (div_dbz) begin
            w_load     = 1'b1;
            w_load_q   = '1;
            w_load_r   = div_x;
            w_load_dbz = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (div_out_valid) begin
          w_load      = 1'b1;
          w_load_q    = div_q;
          w_load_r    = div_r;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Result register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      m_valid <= 1'b0;
      m_q     <= '0;
      m_r     <= '0;
      m_dbz   <= 1'b0;
    end else if (w_load) begin
      m_valid <= 1'b1;
      m_q     <= w_load_q;
      m_r     <= w_load_r;
      m_dbz   <= w_load_dbz;
    end else if (w_drain) begin
      m_valid <= 1'b0;
    end
  end

`ifdef DIV_FEEDER_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating drain statistics
  // --------------------------------------------------------------------------
  logic [15:0] r_stat_jobs;
  logic [15:0] r_stat_dbz;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_stat_jobs <= '0;
      r_stat_dbz  <= '0;
    end else if (w_drain) begin
      if (r_stat_jobs != 16'hFFFF) begin
        r_stat_jobs <= r_stat_jobs + 16'd1;
      end
      if (m_dbz && (r_stat_dbz != 16'hFFFF)) begin
        r_stat_dbz <= r_stat_dbz + 16'd1;
      end
    end
  end

  assign stat_jobs = r_stat_jobs;
  assign stat_dbz  = r_stat_dbz;
`else
  // Statistics counters are absent in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_feeder
// Brief    : Scoreboard bench for div_feeder with a behavioural divider.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_div_feeder;

  localparam int WIDTH   = 4;
  localparam int DEPTH   = 4;
  localparam int DIV_LAT = 4;

  logic             clk = 1'b0;
  logic             nrst;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_x;
  logic [WIDTH-1:0] s_y;
  logic             div_in_valid;
  logic             div_in_ready;
  logic [WIDTH-1:0] div_x;
  logic [WIDTH-1:0] div_y;
  logic             div_out_valid;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic             div_dbz;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] m_r;
  logic             m_dbz;
`ifdef DIV_FEEDER_STATS_EN
  logic [15:0]      stat_jobs;
  logic [15:0]      stat_dbz;
`endif

  logic m_ready_fix;
  logic m_ready_rnd;
  logic rnd_mode;
  logic inject;

  assign m_ready = rnd_mode ? m_ready_rnd : m_ready_fix;

  always #5 clk = ~clk;

  div_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_x           (s_x),
    .s_y           (s_y),
    .div_in_valid  (div_in_valid),
    .div_in_ready  (div_in_ready),
    .div_x         (div_x),
    .div_y         (div_y),
    .div_out_valid (div_out_valid),
    .div_q         (div_q),
    .div_r         (div_r),
    .div_dbz       (div_dbz),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_q           (m_q),
    .m_r           (m_r),
    .m_dbz         (m_dbz)
`ifdef DIV_FEEDER_STATS_EN
    ,
    .stat_jobs     (stat_jobs),
    .stat_dbz      (stat_dbz)
`endif
  );

  // Behavioural multi-cycle divider; divide-by-zero is flagged at issue and never started.
  logic             dv_busy;
  int               dv_cnt;
  logic             dv_ov;
  logic [WIDTH-1:0] dv_q;
  logic [WIDTH-1:0] dv_r;

  assign div_in_ready  = !dv_busy;
  assign div_dbz       = (div_y == '0);
  assign div_out_valid = dv_ov | inject;
  assign div_q         = dv_q;
  assign div_r         = dv_r;

  always @(posedge clk) begin
    if (!nrst) begin
      dv_busy <= 1'b0;
      dv_cnt  <= 0;
      dv_ov   <= 1'b0;
      dv_q    <= '0;
      dv_r    <= '0;
    end else begin
      dv_ov <= 1'b0;
      if (dv_busy) begin
        if (dv_cnt == 0) begin
          dv_ov   <= 1'b1;
          dv_busy <= 1'b0;
        end else begin
          dv_cnt <= dv_cnt - 1;
        end
      end else if (div_in_valid && (div_y != '0)) begin
        dv_busy <= 1'b1;
        dv_cnt  <= DIV_LAT - 1;
        dv_q    <= div_x / div_y;
        dv_r    <= div_x % div_y;
      end
    end
  end

  // Scoreboard
  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic res_t ref_div(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    res_t res;
    if (y == 0) begin
      res.q   = {WIDTH{1'b1}};
      res.r   = x;
      res.dbz = 1'b1;
    end else begin
      res.q   = x / y;
      res.r   = x % y;
      res.dbz = 1'b0;
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one pair; expectation is queued only once the handshake is certain.
  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int t = 0;
    s_valid = 1'b1;
    s_x     = x;
    s_y     = y;
    while (!s_ready && t < 300) begin
      tick();
      t++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got s_ready=0 expected 1 within 300 cycles");
    end else begin
      exp_q.push_back(ref_div(x, y));
    end
    tick();
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 2000) begin
      tick();
      t++;
    end
    total++;
    if (exp_q.size() != 0 || m_valid) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  // Monitor: pops on every output handshake and checks held outputs stay stable.
  initial begin
    logic held;
    res_t hv;
    res_t act;
    res_t req;
    held = 1'b0;
    hv   = '0;
    forever begin
      @(negedge clk);
      if (nrst !== 1'b1) begin
        held = 1'b0;
      end else begin
        act = '{q: m_q, r: m_r, dbz: m_dbz};
        if (held && m_valid) begin
          total++;
          if (act !== hv) begin
            bad++;
            $display("FAIL hold: got %0h expected %0h", act, hv);
          end
        end
        if (m_valid && m_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_result: got q=%0h r=%0h dbz=%0b expected none", m_q, m_r, m_dbz);
          end else begin
            req = exp_q.pop_front();
            if (act !== req) begin
              bad++;
              $display("FAIL result: got q=%0h r=%0h dbz=%0b expected q=%0h r=%0h dbz=%0b",
                       act.q, act.r, act.dbz, req.q, req.r, req.dbz);
            end
          end
          held = 1'b0;
        end else if (m_valid) begin
          held = 1'b1;
          hv   = act;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    m_ready_rnd = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready_rnd = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int t;
    nrst        = 1'b0;
    s_valid     = 1'b0;
    s_x         = '0;
    s_y         = '0;
    m_ready_fix = 1'b1;
    rnd_mode    = 1'b0;
    inject      = 1'b0;
    repeat (3) tick();
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_m_q", 32'(m_q), 32'd0);
    chk("reset_m_r", 32'(m_r), 32'd0);
    chk("reset_m_dbz", 32'(m_dbz), 32'd0);
    chk("reset_s_ready", 32'(s_ready), 32'd1);
    chk("reset_div_in_valid", 32'(div_in_valid), 32'd0);
    nrst = 1'b1;
    tick();

    send(4'd13, 4'd4);
    s_valid = 1'b0;
    wait_drain();

    send(4'd9, 4'd0);
    send(4'd7, 4'd2);
    s_valid = 1'b0;
    wait_drain();

    // Back-pressure: one job in the result register, four in the FIFO.
    m_ready_fix = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(4'(15 - i), 4'(i + 1));
    end
    s_valid = 1'b1;
    s_x     = 4'd10;
    s_y     = 4'd6;
    repeat (12) tick();
    chk("full_s_ready", 32'(s_ready), 32'd0);
    chk("full_m_valid", 32'(m_valid), 32'd1);
    chk("full_m_q", 32'(m_q), 32'd15);
    m_ready_fix = 1'b1;
    t = 0;
    while (!s_ready && t < 300) begin
      tick();
      t++;
    end
    chk("sixth_accepted", 32'(s_ready), 32'd1);
    if (s_ready) begin
      exp_q.push_back(ref_div(4'd10, 4'd6));
    end
    tick();
    s_valid = 1'b0;
    wait_drain();

    for (int i = 0; i < 8; i++) begin
      send(4'($urandom), 4'($urandom));
    end
    s_valid = 1'b0;
    wait_drain();

    rnd_mode = 1'b1;
    for (int i = 0; i < 30; i++) begin
      send(4'($urandom), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 6)) tick();
      end
    end
    s_valid = 1'b0;
    wait_drain();
    rnd_mode = 1'b0;

    // Reset while a job is outstanding and three are queued.
    send(4'd15, 4'd2);
    send(4'd14, 4'd3);
    send(4'd13, 4'd4);
    send(4'd12, 4'd5);
    s_valid = 1'b0;
    nrst    = 1'b0;
    exp_q.delete();
    tick();
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd1);
    nrst = 1'b1;
    repeat (30) tick();
    chk("midrst_no_stale", 32'(m_valid), 32'd0);

`ifdef DIV_FEEDER_STATS_EN
    send(4'd11, 4'd3);
    send(4'd8, 4'd2);
    send(4'd5, 4'd5);
    send(4'd4, 4'd0);
    send(4'd0, 4'd0);
    s_valid = 1'b0;
    wait_drain();
    chk("stat_jobs", 32'(stat_jobs), 32'd5);
    chk("stat_dbz", 32'(stat_dbz), 32'd2);
    force dut.r_stat_jobs = 16'hFFFF;
    force dut.r_stat_dbz  = 16'hFFFF;
    tick();
    release dut.r_stat_jobs;
    release dut.r_stat_dbz;
    send(4'd3, 4'd0);
    s_valid = 1'b0;
    wait_drain();
    chk("stat_jobs_sat", 32'(stat_jobs), 32'hFFFF);
    chk("stat_dbz_sat", 32'(stat_dbz), 32'hFFFF);
`endif

    // A stray divider strobe while idle must not produce a result.
    inject = 1'b1;
    tick();
    inject = 1'b0;
    repeat (5) tick();
    chk("stray_strobe_ignored", 32'(m_valid), 32'd0);
    send(4'd6, 4'd3);
    s_valid = 1'b0;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
